// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default timing for the PWM duty-cycle controller front end.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StRepeat = 2'd2
  } btn_state_e;

  localparam int unsigned DefSyncStages     = 2;
  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefRepeatDelay    = 40;
  localparam int unsigned DefRepeatPeriod   = 20;
  localparam int unsigned DefRepeatEn       = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned step/level outputs of button_conditioner.
interface button_conditioner_if;

  logic btn_inc_raw;
  logic btn_dec_raw;
  logic increase_duty;
  logic decrease_duty;
  logic inc_level;
  logic dec_level;

  modport master (
    output btn_inc_raw,
    output btn_dec_raw,
    input  increase_duty,
    input  decrease_duty,
    input  inc_level,
    input  dec_level
  );

  modport slave (
    input  btn_inc_raw,
    input  btn_dec_raw,
    output increase_duty,
    output decrease_duty,
    output inc_level,
    output dec_level
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce counter and press/auto-repeat FSM.
// The pulse output is combinational; the top level registers it.
module debounce_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
  parameter int unsigned REPEAT_EN       = DefRepeatEn
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RpW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  // Reload with N-1 so the pulse lands exactly N cycles after the previous one.
  localparam logic [RpW-1:0] DelayLoad  = RpW'(REPEAT_DELAY - 1);
  localparam logic [RpW-1:0] PeriodLoad = RpW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  btn_state_e             state_q, state_d;
  logic [RpW-1:0]         rp_cnt_q, rp_cnt_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (synced != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    pulse    = 1'b0;
    if (!level_q) begin
      state_d  = StIdle;
      rp_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pulse    = 1'b1;
          rp_cnt_d = DelayLoad;
          state_d  = StDelay;
        end
        StDelay: begin
          if (rp_cnt_q == '0) begin
            // Without auto-repeat the channel parks here until release.
            if (REPEAT_EN != 0) begin
              pulse    = 1'b1;
              rp_cnt_d = PeriodLoad;
              state_d  = StRepeat;
            end
          end else begin
            rp_cnt_d = rp_cnt_q - 1'b1;
          end
        end
        StRepeat: begin
          if (rp_cnt_q == '0) begin
            pulse    = 1'b1;
            rp_cnt_d = PeriodLoad;
          end else begin
            rp_cnt_d = rp_cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      state_q  <= StIdle;
      rp_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced inc/dec push-buttons to single-cycle duty-step pulses with auto-repeat;
// both outputs are muted while both buttons are held.
module button_conditioner
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
  parameter int unsigned REPEAT_EN       = DefRepeatEn
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  logic inc_lvl, dec_lvl;
  logic inc_pulse, dec_pulse;
  logic both_held;
  logic inc_d, dec_d;
  logic inc_q, dec_q;
  logic inc_level_q, dec_level_q;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (REPEAT_EN)
  ) u_inc (
    .clk  (clk),
    .reset(reset),
    .raw  (bus.btn_inc_raw),
    .level(inc_lvl),
    .pulse(inc_pulse)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REPEAT_EN      (REPEAT_EN)
  ) u_dec (
    .clk  (clk),
    .reset(reset),
    .raw  (bus.btn_dec_raw),
    .level(dec_lvl),
    .pulse(dec_pulse)
  );

  // A coincident pulse pair is dropped so the two steps can never both reach the PWM.
  always_comb begin
    both_held = inc_lvl & dec_lvl;
    inc_d     = inc_pulse & ~dec_pulse & ~both_held;
    dec_d     = dec_pulse & ~inc_pulse & ~both_held;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      inc_level_q <= 1'b0;
      dec_level_q <= 1'b0;
    end else begin
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      inc_level_q <= inc_lvl;
      dec_level_q <= dec_lvl;
    end
  end

  assign bus.increase_duty = inc_q;
  assign bus.decrease_duty = dec_q;
  assign bus.inc_level     = inc_level_q;
  assign bus.dec_level     = dec_level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed press scenarios plus random button/reset
// activity, checked every cycle against a timing model of two instances.
module tb_button_conditioner;
  import pwm_ctrl_pkg::*;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int RD = 40;
  localparam int RP = 20;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic inc_raw = 1'b0;
  logic dec_raw = 1'b0;

  always #5 clk = ~clk;

  button_conditioner_if bus_rep ();
  button_conditioner_if bus_one ();

  assign bus_rep.btn_inc_raw = inc_raw;
  assign bus_rep.btn_dec_raw = dec_raw;
  assign bus_one.btn_inc_raw = inc_raw;
  assign bus_one.btn_dec_raw = dec_raw;

  button_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
  ) dut_rep (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_rep)
  );

  button_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)
  ) dut_one (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_one)
  );

  // Model: raw history per button, last D synchronised samples, level and hold time.
  bit         rh   [2][S];
  bit         sh   [2][D];
  bit         lvl  [2];
  int         hold [2];
  logic [3:0] exp_o[2];   // {increase_duty, decrease_duty, inc_level, dec_level}

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;
  bit checking = 1'b0;

  logic [3:0] act0, act1;
  int inc_t0[$], dec_t0[$], inc_t1[$], dec_t1[$];
  int li_first, li_last;
  bit both_seen, rst_hi_seen;

  // Pulse h cycles after the level rose: first press, then DELAY, then every PERIOD.
  function automatic bit fires(input int h, input bit rep_en);
    if (h == 0) return 1'b1;
    if (!rep_en || h < RD) return 1'b0;
    return ((h - RD) % RP) == 0;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < S; j++) rh[c][j] = 1'b0;
      for (int j = 0; j < D; j++) sh[c][j] = 1'b0;
      lvl[c]   = 1'b0;
      hold[c]  = 0;
      exp_o[c] = '0;
    end
  endtask

  task automatic model_step();
    bit both, p_i, p_d, sy, all_diff;
    bit raw_now[2];
    raw_now[0] = inc_raw;
    raw_now[1] = dec_raw;
    both = lvl[0] && lvl[1];
    for (int i = 0; i < 2; i++) begin
      p_i = lvl[0] && fires(hold[0], i == 0);
      p_d = lvl[1] && fires(hold[1], i == 0);
      exp_o[i] = {p_i && !both && !p_d, p_d && !both && !p_i, lvl[0], lvl[1]};
    end
    for (int c = 0; c < 2; c++) begin
      sy = rh[c][S-1];
      for (int j = S - 1; j > 0; j--) rh[c][j] = rh[c][j-1];
      rh[c][0] = raw_now[c];
      for (int j = D - 1; j > 0; j--) sh[c][j] = sh[c][j-1];
      sh[c][0] = sy;
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) if (sh[c][j] == lvl[c]) all_diff = 1'b0;
      if (all_diff) begin
        lvl[c]  = !lvl[c];
        hold[c] = 0;
      end else begin
        hold[c]++;
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      act0 = {bus_rep.increase_duty, bus_rep.decrease_duty, bus_rep.inc_level, bus_rep.dec_level};
      act1 = {bus_one.increase_duty, bus_one.decrease_duty, bus_one.inc_level, bus_one.dec_level};
      n_vec++;
      if (act0 !== exp_o[0]) begin
        n_err++;
        $display("FAIL outputs_rep cyc %0d: got %b want %b (inc,dec,inc_lvl,dec_lvl)",
                 cyc, act0, exp_o[0]);
      end
      n_vec++;
      if (act1 !== exp_o[1]) begin
        n_err++;
        $display("FAIL outputs_one cyc %0d: got %b want %b (inc,dec,inc_lvl,dec_lvl)",
                 cyc, act1, exp_o[1]);
      end
      if (act0[3]) inc_t0.push_back(cyc - base);
      if (act0[2]) dec_t0.push_back(cyc - base);
      if (act1[3]) inc_t1.push_back(cyc - base);
      if (act1[2]) dec_t1.push_back(cyc - base);
      if (act0[1]) begin
        if (li_first < 0) li_first = cyc - base;
        li_last = cyc - base;
      end
      if (act0[1] && act0[0]) both_seen = 1'b1;
      if (!reset && (act0 != 4'b0 || act1 != 4'b0)) rst_hi_seen = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_scen();
    inc_t0.delete();
    dec_t0.delete();
    inc_t1.delete();
    dec_t1.delete();
    li_first    = -1;
    li_last     = -1;
    both_seen   = 1'b0;
    rst_hi_seen = 1'b0;
    base        = cyc;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input int act[$], input int exp[$]);
    bit ok;
    ok = (act.size() == exp.size());
    if (ok) for (int k = 0; k < act.size(); k++) if (act[k] != exp[k]) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got pulse cycles %p want %p", name, act, exp);
    end
  endtask

  initial begin
    int e[$];
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    checking = 1'b1;
    tick(5);

    // Clean 10-cycle press.
    start_scen();
    inc_raw = 1'b1;
    tick(10);
    inc_raw = 1'b0;
    tick(30);
    e = '{7};
    check_q("s1_inc_pulses", inc_t0, e);
    check_int("s1_dec_count", dec_t0.size(), 0);
    check_int("s1_inc_level_first", li_first, 7);
    check_int("s1_inc_level_last", li_last, 16);

    // Bounce shorter than the debounce window.
    start_scen();
    for (int k = 0; k < 16; k++) begin
      inc_raw = (k % 2 == 0);
      tick(1);
    end
    inc_raw = 1'b0;
    tick(30);
    check_int("s2_inc_count", inc_t0.size(), 0);
    check_int("s2_inc_level_first", li_first, -1);

    // Long hold with auto-repeat; the one-shot instance sees the same press.
    start_scen();
    inc_raw = 1'b1;
    tick(90);
    inc_raw = 1'b0;
    tick(60);
    e = '{7, 47, 67, 87};
    check_q("s3_inc_pulses", inc_t0, e);
    check_int("s3_dec_count", dec_t0.size(), 0);
    e = '{7};
    check_q("s6_oneshot_inc_pulses", inc_t1, e);

    // Both buttons together.
    start_scen();
    inc_raw = 1'b1;
    dec_raw = 1'b1;
    tick(30);
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    tick(30);
    check_int("s4_inc_count", inc_t0.size(), 0);
    check_int("s4_dec_count", dec_t0.size(), 0);
    check_int("s4_both_levels", int'(both_seen), 1);

    // Reset while decrease is held.
    start_scen();
    dec_raw = 1'b1;
    tick(30);
    reset = 1'b0;
    tick(10);
    reset = 1'b1;
    tick(20);
    dec_raw = 1'b0;
    tick(30);
    e = '{7, 47};
    check_q("s5_dec_pulses", dec_t0, e);
    check_int("s5_inc_count", inc_t0.size(), 0);
    check_int("s5_outputs_in_reset", int'(rst_hi_seen), 0);

    // Random presses, bounce and occasional resets against the model.
    for (int s = 0; s < 150; s++) begin
      inc_raw = 1'($urandom_range(0, 1));
      dec_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        tick(int'($urandom_range(1, 4)));
        reset = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) tick(int'($urandom_range(1, 6)));
      else tick(int'($urandom_range(10, 110)));
    end
    inc_raw = 1'b0;
    dec_raw = 1'b0;
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
